// File: rtl/sensor_poll_sched.sv
// rtl/sensor_poll_sched.sv - periodic local/remote temperature poll scheduler with change-threshold reporting
module sensor_poll_sched (
    input  logic        Reset_n_i,
    input  logic        Clk_i,
    input  logic        Enable_i,
    input  logic [15:0] ParamPeriod_i,
    input  logic [15:0] ParamThreshold_i,
    output logic        QueryLocal_o,
    output logic        QueryRemote_o,
    input  logic        Done_i,
    input  logic        Error_i,
    input  logic [7:0]  Byte0_i,
    input  logic [7:0]  Byte1_i,
    output logic [15:0] LocalTemp_o,
    output logic [15:0] RemoteTemp_o,
    output logic        CpuIntr_o,
    output logic        Error_o,
    output logic        Busy_o
);

    typedef enum logic [2:0] {
        stDisabled,
        stIdle,
        stQueryLocal,
        stWaitLocal,
        stQueryRemote,
        stWaitRemote,
        stNotify
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] local_shadow_q, local_shadow_d;
    logic [15:0] remote_shadow_q, remote_shadow_d;
    logic [15:0] local_temp_q, local_temp_d;
    logic [15:0] remote_temp_q, remote_temp_d;
    logic        valid_q, valid_d;

    logic [16:0] local_diff, remote_diff;
    logic [16:0] local_mag, remote_mag;
    logic [16:0] threshold_ext;
    logic        report;

    // Sign-extend to 17 bits so the difference cannot wrap, e.g. 0x7FFF vs 0x8000 -> 0xFFFF.
    assign local_diff    = {local_shadow_q[15], local_shadow_q} - {local_temp_q[15], local_temp_q};
    assign remote_diff   = {remote_shadow_q[15], remote_shadow_q} - {remote_temp_q[15], remote_temp_q};
    assign local_mag     = local_diff[16] ? (~local_diff + 17'd1) : local_diff;
    assign remote_mag    = remote_diff[16] ? (~remote_diff + 17'd1) : remote_diff;
    assign threshold_ext = {1'b0, ParamThreshold_i};
    assign report        = (local_mag > threshold_ext) || (remote_mag > threshold_ext) || !valid_q;

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q         <= stDisabled;
            timer_q         <= 16'h0000;
            local_shadow_q  <= 16'h0000;
            remote_shadow_q <= 16'h0000;
            local_temp_q    <= 16'h0000;
            remote_temp_q   <= 16'h0000;
            valid_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            local_shadow_q  <= local_shadow_d;
            remote_shadow_q <= remote_shadow_d;
            local_temp_q    <= local_temp_d;
            remote_temp_q   <= remote_temp_d;
            valid_q         <= valid_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        local_shadow_d  = local_shadow_q;
        remote_shadow_d = remote_shadow_q;
        local_temp_d    = local_temp_q;
        remote_temp_d   = remote_temp_q;
        valid_d         = valid_q;
        QueryLocal_o    = 1'b0;
        QueryRemote_o   = 1'b0;
        CpuIntr_o       = 1'b0;
        Error_o         = 1'b0;
        Busy_o          = 1'b0;

        case (state_q)
            stDisabled: begin
                timer_d = ParamPeriod_i;
                if (Enable_i) begin
                    state_d = stIdle;
                end
            end
            stIdle: begin
                if (!Enable_i) begin
                    state_d = stDisabled;
                end else if (timer_q == 16'h0000) begin
                    state_d = stQueryLocal;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            stQueryLocal: begin
                QueryLocal_o = 1'b1;
                Busy_o       = 1'b1;
                state_d      = stWaitLocal;
            end
            stWaitLocal: begin
                Busy_o = 1'b1;
                if (Error_i) begin
                    Error_o   = 1'b1;
                    CpuIntr_o = 1'b1;
                    timer_d   = ParamPeriod_i;
                    state_d   = stIdle;
                end else if (Done_i) begin
                    local_shadow_d = {Byte1_i, Byte0_i};
                    state_d        = stQueryRemote;
                end
            end
            stQueryRemote: begin
                QueryRemote_o = 1'b1;
                Busy_o        = 1'b1;
                state_d       = stWaitRemote;
            end
            stWaitRemote: begin
                Busy_o = 1'b1;
                if (Error_i) begin
                    Error_o   = 1'b1;
                    CpuIntr_o = 1'b1;
                    timer_d   = ParamPeriod_i;
                    state_d   = stIdle;
                end else if (Done_i) begin
                    remote_shadow_d = {Byte1_i, Byte0_i};
                    state_d         = stNotify;
                end
            end
            stNotify: begin
                Busy_o = 1'b1;
                if (report) begin
                    local_temp_d  = local_shadow_q;
                    remote_temp_d = remote_shadow_q;
                    valid_d       = 1'b1;
                    CpuIntr_o     = 1'b1;
                end
                timer_d = ParamPeriod_i;
                state_d = stIdle;
            end
            default: begin
                state_d = stDisabled;
            end
        endcase
    end

    assign LocalTemp_o  = local_temp_q;
    assign RemoteTemp_o = remote_temp_q;

endmodule
